// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types, defaults and helpers for the ADC capture sequencer
//
// Contents:
//   state_e        sequencer state encoding
//   DEF_*          default timing parameters for adc_capture_sequencer
//   max3()         maximum of three phase lengths
//   cnt_width()    wait-counter width able to hold (longest phase - 1)
//   norm_len()     cfg_len normalisation: 0 or oversize -> full depth
package adc_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLKRST  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ARMED   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int DEF_DATA_W         = 9;
    localparam int DEF_DEPTH_LOG2     = 10;
    localparam int DEF_CLKRST_CYCLES  = 8;
    localparam int DEF_SETTLE_CYCLES  = 64;
    localparam int DEF_TIMEOUT_CYCLES = 65536;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The counter is loaded with N-1 and counts down to 0, so clog2(N) bits
    // are enough for the longest phase.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = max3(a, b, c);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    function automatic int unsigned norm_len(input int unsigned cfg,
                                             input int unsigned depth_log2);
        int unsigned depth;
        depth = 32'd1 << depth_log2;
        if (cfg == 0 || cfg > depth) begin
            return depth;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/adc_capture_wait_cnt.sv
// rtl/adc_capture_wait_cnt.sv - loadable down-counter with zero flag for phase timing
//
// Ports:
//   clock     block clock
//   reset     asynchronous active-low reset
//   load      load load_val this cycle (wins over dec)
//   load_val  value to load
//   dec       decrement by one; saturates at zero
//   zero      counter currently holds zero
module adc_capture_wait_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/adc_capture_sequencer.sv
// rtl/adc_capture_sequencer.sv - ADC snapshot capture sequencer (clkrst, settle, arm, stream to SRAM)
//
// Optional build macro: ADC_CAPTURE_TIMEOUT_EN enables the ARMED watchdog and
// the sticky timeout flag; otherwise ARMED waits indefinitely and timeout is 0.
//
// Ports:
//   clock, reset          block clock, asynchronous active-low reset
//   start, abort          capture request / cancel (abort wins)
//   cfg_len               samples to capture, 0 = full depth; latched on start
//   trig                  level trigger sampled in ARMED
//   adc_valid, adc_data   ADC sample stream
//   clkrst                ADC clock-divider reset
//   mem_wen/addr/wdata    capture SRAM write port
//   busy, done            status (busy outside IDLE/DONE, done level in DONE)
//   captured              samples written so far
//   timeout               sticky ARMED-watchdog flag
module adc_capture_sequencer
    import adc_capture_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
    parameter int CLKRST_CYCLES  = DEF_CLKRST_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DEPTH_LOG2:0]   cfg_len,
    input  logic                  trig,
    input  logic                  adc_valid,
    input  logic [DATA_W-1:0]     adc_data,
    output logic                  clkrst,
    output logic                  mem_wen,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   captured,
    output logic                  timeout
);

    localparam int LEN_W = DEPTH_LOG2 + 1;
    localparam int CNT_W = int'(cnt_width(CLKRST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES));

    state_e                state_q,     state_d;
    logic [LEN_W-1:0]      len_q,       len_d;
    logic [LEN_W-1:0]      captured_q,  captured_d;
    logic                  clkrst_q,    clkrst_d;
    logic                  mem_wen_q,   mem_wen_d;
    logic [DEPTH_LOG2-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  take_sample;

`ifdef ADC_CAPTURE_TIMEOUT_EN
    logic                  timeout_q,   timeout_d;
`endif

    adc_capture_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        captured_d   = captured_q;
        clkrst_d     = clkrst_q;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        take_sample  = 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif

        if (abort) begin
            // A write already registered for this cycle still completes;
            // nothing further is issued.
            state_d  = ST_IDLE;
            clkrst_d = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len_d        = LEN_W'(norm_len(32'(cfg_len), DEPTH_LOG2));
                        captured_d   = '0;
                        done_d       = 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
                        timeout_d    = 1'b0;
`endif
                        state_d      = ST_CLKRST;
                        clkrst_d     = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(CLKRST_CYCLES - 1);
                    end
                end
                ST_CLKRST: begin
                    if (cnt_zero) begin
                        state_d      = ST_SETTLE;
                        clkrst_d     = 1'b0;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state_d = ST_ARMED;
`ifdef ADC_CAPTURE_TIMEOUT_EN
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_ARMED: begin
                    // A sample valid in the trigger cycle is capture index 0.
                    if (trig) begin
                        state_d     = ST_CAPTURE;
                        take_sample = adc_valid;
`ifdef ADC_CAPTURE_TIMEOUT_EN
                    end else if (cnt_zero) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
`endif
                    end
                end
                ST_CAPTURE: begin
                    // captured reaches len in the cycle the final write is
                    // on the port; the following cycle is DONE.
                    if (captured_q == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        take_sample = adc_valid;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (take_sample) begin
            mem_wen_d   = 1'b1;
            mem_addr_d  = captured_q[DEPTH_LOG2-1:0];
            mem_wdata_d = adc_data;
            captured_d  = captured_q + 1'b1;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            captured_q  <= '0;
            clkrst_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            captured_q  <= captured_d;
            clkrst_q    <= clkrst_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef ADC_CAPTURE_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign clkrst    = clkrst_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign captured  = captured_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb/tb_adc_capture_sequencer.sv - directed self-checking bench for adc_capture_sequencer
module tb_adc_capture_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [4:0] cfg_len;
    logic       trig;
    logic       adc_valid;
    logic [8:0] adc_data;
    logic       clkrst;
    logic       mem_wen;
    logic [3:0] mem_addr;
    logic [8:0] mem_wdata;
    logic       busy;
    logic       done;
    logic [4:0] captured;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    adc_capture_sequencer #(
        .DATA_W         (9),
        .DEPTH_LOG2     (4),
        .CLKRST_CYCLES  (4),
        .SETTLE_CYCLES  (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .trig      (trig),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .clkrst    (clkrst),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .captured  (captured),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clkrst"},   32'(clkrst),    0);
        chk({tag, "_wen"},      32'(mem_wen),   0);
        chk({tag, "_addr"},     32'(mem_addr),  0);
        chk({tag, "_wdata"},    32'(mem_wdata), 0);
        chk({tag, "_busy"},     32'(busy),      0);
        chk({tag, "_done"},     32'(done),      0);
        chk({tag, "_captured"}, 32'(captured),  0);
        chk({tag, "_timeout"},  32'(timeout),   0);
    endtask

    task automatic do_start(input logic [4:0] len);
        cfg_len = len;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Called in the first CLKRST cycle; returns in the first ARMED cycle.
    task automatic run_to_armed(input bit pulse_start_in_settle);
        for (int i = 0; i < 4; i++) begin
            chk("clkrst_high", 32'(clkrst), 1);
            chk("clkrst_busy", 32'(busy), 1);
            chk("clkrst_nowen", 32'(mem_wen), 0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            chk("settle_clkrst_low", 32'(clkrst), 0);
            chk("settle_nowen", 32'(mem_wen), 0);
            chk("settle_busy", 32'(busy), 1);
            start = (pulse_start_in_settle && i == 2);
            if (start) cfg_len = 5'd1;
            step();
        end
        start = 1'b0;
        chk("armed_clkrst_low", 32'(clkrst), 0);
    endtask

    task automatic basic_capture();
        trig      = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 9'h101;
        do_start(5'd5);
        run_to_armed(1'b0);
        chk("basic_armed_nowen", 32'(mem_wen), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("basic_wen",      32'(mem_wen),   1);
            chk("basic_addr",     32'(mem_addr),  32'(i));
            chk("basic_wdata",    32'(mem_wdata), 32'(9'h101 + i));
            chk("basic_captured", 32'(captured),  32'(i + 1));
            chk("basic_notdone",  32'(done),      0);
            adc_data = 9'(9'h102 + i);
        end
        step();
        chk("basic_done",     32'(done),     1);
        chk("basic_done_wen", 32'(mem_wen),  0);
        chk("basic_done_cap", 32'(captured), 5);
        chk("basic_done_busy",32'(busy),     0);
        chk("basic_timeout",  32'(timeout),  0);
        trig      = 1'b0;
        adc_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_len   = '0;
        trig      = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        #2;
        chk_all_zero("reset");
        step();
        step();
        reset = 1'b1;
        step();
        chk_all_zero("post_reset");

        // Basic capture, trig held and sample valid from the first ARMED cycle
        basic_capture();

        // Full depth (cfg_len=0) with valid every other cycle
        trig      = 1'b1;
        adc_valid = 1'b0;
        do_start(5'd0);
        chk("full_clears_done", 32'(done), 0);
        chk("full_clears_cap",  32'(captured), 0);
        run_to_armed(1'b0);
        for (int k = 0; k < 16; k++) begin
            adc_valid = 1'b1;
            adc_data  = 9'(9'h020 + k);
            step();
            chk("full_wen",   32'(mem_wen),   1);
            chk("full_addr",  32'(mem_addr),  32'(k));
            chk("full_wdata", 32'(mem_wdata), 32'(9'h020 + k));
            adc_valid = 1'b0;
            step();
            chk("full_gap_nowen", 32'(mem_wen), 0);
        end
        chk("full_done",     32'(done),     1);
        chk("full_captured", 32'(captured), 16);
        trig = 1'b0;

        // Trigger and valid in the same cycle after idle ARMED cycles
        do_start(5'd2);
        run_to_armed(1'b0);
        step();
        step();
        chk("trig_wait_nowen", 32'(mem_wen), 0);
        chk("trig_wait_busy",  32'(busy), 1);
        trig      = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 9'h0AA;
        step();
        chk("trig_wen",   32'(mem_wen),   1);
        chk("trig_addr",  32'(mem_addr),  0);
        chk("trig_wdata", 32'(mem_wdata), 32'h0AA);
        trig     = 1'b0;
        adc_data = 9'h0BB;
        step();
        chk("trig_ign_addr",  32'(mem_addr),  1);
        chk("trig_ign_wdata", 32'(mem_wdata), 32'h0BB);
        adc_valid = 1'b0;
        step();
        chk("trig_done",     32'(done),     1);
        chk("trig_captured", 32'(captured), 2);

        // Start in SETTLE ignored, then abort after three writes
        trig      = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 9'h001;
        do_start(5'd6);
        run_to_armed(1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_pre_addr", 32'(mem_addr), 32'(i));
            adc_data = 9'(9'h002 + i);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy",     32'(busy),     0);
        chk("abort_done",     32'(done),     0);
        chk("abort_wen",      32'(mem_wen),  0);
        chk("abort_clkrst",   32'(clkrst),   0);
        chk("abort_captured", 32'(captured), 3);
        step();
        chk("abort_stays_idle", 32'(busy), 0);

        // Abort and start together from DONE: abort wins
        adc_data = 9'h055;
        do_start(5'd1);
        run_to_armed(1'b0);
        step();
        chk("one_wdata", 32'(mem_wdata), 32'h055);
        step();
        chk("one_done", 32'(done), 1);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abst_busy",     32'(busy),     0);
        chk("abst_done",     32'(done),     0);
        chk("abst_clkrst",   32'(clkrst),   0);
        chk("abst_captured", 32'(captured), 1);
        step();
        chk("abst_no_clkrst", 32'(clkrst), 0);

        // Asynchronous reset mid-capture at address 7
        adc_data = 9'h070;
        do_start(5'd0);
        run_to_armed(1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            adc_data = 9'(9'h071 + i);
        end
        chk("midrst_addr", 32'(mem_addr), 7);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        trig      = 1'b0;
        adc_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        basic_capture();

`ifdef ADC_CAPTURE_TIMEOUT_EN
        // Watchdog: trig low, valid high, no writes ever
        trig      = 1'b0;
        adc_valid = 1'b1;
        do_start(5'd5);
        run_to_armed(1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("to_armed_busy",  32'(busy),    1);
            chk("to_armed_nowen", 32'(mem_wen), 0);
            step();
        end
        chk("to_done",     32'(done),     1);
        chk("to_flag",     32'(timeout),  1);
        chk("to_captured", 32'(captured), 0);
        chk("to_nowen",    32'(mem_wen),  0);
        adc_valid = 1'b0;
        do_start(5'd5);
        chk("to_clear", 32'(timeout), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
- Sequences the on-chip ADC front end for a snapshot capture.
- Pulses the ADC clock-divider reset (CLKRST), waits for clocks to settle, arms on a trigger, then streams a fixed-length block of ADC samples into a capture SRAM.
- Sits between the chip's control/serial register block and the ADC/SRAM datapath; software starts a capture and later reads the buffer back.

Parameters:
- DATA_W, 9, ADC sample width in bits.
- DEPTH_LOG2, 10, log2 of capture SRAM depth in samples.
- CLKRST_CYCLES, 8, number of cycles clkrst is held high; must be ≥1.
- SETTLE_CYCLES, 64, wait after clkrst release before arming; must be ≥1.
- TIMEOUT_CYCLES, 65536, ARMED watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  single block clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle capture request.
- abort  in  1  cancels any operation.
- cfg_len  in  DEPTH_LOG2+1  samples to capture; 0 means 2^DEPTH_LOG2; latched on an accepted start.
- trig  in  1  capture trigger, level-sampled.
- adc_valid  in  1  adc_data is valid this cycle.
- adc_data  in  DATA_W  ADC sample.
- clkrst  out  1  ADC clock-divider reset.
- mem_wen  out  1  SRAM write enable.
- mem_addr  out  DEPTH_LOG2  SRAM write address.
- mem_wdata  out  DATA_W  SRAM write data.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  capture complete; level.
- captured  out  DEPTH_LOG2+1  number of samples written so far.
- timeout  out  1  sticky ARMED-watchdog flag.

Behaviour:
- Reset state: all outputs 0, state IDLE, all counters 0. Reset is asynchronous assert, synchronous-release domain.
- States: IDLE, CLKRST, SETTLE, ARMED, CAPTURE, DONE. All outputs are registered.
- IDLE/DONE + start:
  - Latch len = (cfg_len==0 ? 2^DEPTH_LOG2 : min(cfg_len, 2^DEPTH_LOG2)).
  - Clear captured, done and timeout; go to CLKRST.
  - start is ignored in every other state.
- CLKRST: clkrst=1 for exactly CLKRST_CYCLES cycles, then go to SETTLE.
- SETTLE: clkrst=0; wait exactly SETTLE_CYCLES cycles, then go to ARMED.
- ARMED: on trig=1, go to CAPTURE.
  - If adc_valid=1 in the same cycle, that sample is capture index 0.
- CAPTURE: each adc_valid cycle writes one sample.
  - The write appears on the cycle after adc_valid: mem_wen=1, mem_addr=captured[DEPTH_LOG2-1:0], mem_wdata=adc_data.
  - captured increments in the same cycle as mem_wen. Samples without adc_valid are not written.
  - trig is ignored once in CAPTURE.
- Completion: when the write of sample len-1 is issued, the next cycle is DONE with done=1 and mem_wen=0.
  - No write is ever issued beyond len.
  - Address wraps are impossible because len ≤ depth.
- DONE: done held until an accepted start or abort. captured holds its final value.
- abort (any state): next cycle is IDLE.
  - clkrst=0, mem_wen=0, done=0; captured keeps its value.
  - abort has priority over start in the same cycle.
- Simultaneous final write and abort: the write is still issued that cycle; the next state is IDLE, not DONE.
- Reset mid-capture: immediate return to reset state. SRAM contents are undefined to software.

Optional Feature:
- Macro: ADC_CAPTURE_TIMEOUT_EN.
- Enabled:
  - A counter runs while in ARMED.
  - If TIMEOUT_CYCLES cycles elapse without trig, go to DONE with done=1 and timeout=1; captured is 0.
  - timeout clears on the next accepted start.
- Disabled: ARMED waits indefinitely; timeout is tied to 0 and no counter logic is built.

Decomposition:
- Shared package adc_capture_pkg holds:
  - state enum type;
  - localparam for the counter width, computed from max(CLKRST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
  - function normalising cfg_len.
- One natural sub-module: adc_capture_wait_cnt, a loadable down-counter with a zero flag.
  - Shared by CLKRST, SETTLE and timeout phases.

Test Plan:
- Params DATA_W=9, DEPTH_LOG2=4, CLKRST_CYCLES=4, SETTLE_CYCLES=8 for all cases below.
- Basic capture: start, cfg_len=5, trig high in ARMED, adc_valid every cycle with data 0x101..0x105.
  - Required: clkrst high exactly 4 cycles, then 8 settle cycles.
  - Required: writes at addr 0..4 with data 0x101..0x105, each one cycle after its sample.
  - Required: done=1 and captured=5 on the following cycle.
- cfg_len=0 with adc_valid every other cycle: exactly 16 writes at addr 0..15, done with captured=16; valid-low cycles produce no write.
- Trigger with adc_valid in the same cycle, data 0x0AA: 0x0AA is written at addr 0.
- Protocol edge cases: start pulsed during SETTLE is ignored (clkrst count unaffected); abort after 3 writes gives IDLE, busy=0, done=0, captured=3; abort+start in the same cycle from DONE gives IDLE.
- Reset asserted mid-CAPTURE at address 7: outputs go to 0 asynchronously; after release, a fresh start behaves as in the basic-capture case.
- With ADC_CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=20, trig held low: DONE after 20 ARMED cycles with timeout=1, captured=0, and no mem_wen ever asserted.
